// File: rtl/rle_line_decoder_if.sv
// Run-triple input channel and pixel output channel of the RLE line decoder.
// The master side supplies run triples and consumes pixels; the slave side is
// the decoder itself.
interface rle_line_decoder_if;
  logic [9:0] stream1;
  logic [9:0] stream2;
  logic [9:0] stream3;
  logic       in_valid;
  logic       in_ready;
  logic       pixel_out;
  logic       out_valid;
  logic       out_ready;
  logic       line_last;
  logic       len_err;

  modport master (
    output stream1, stream2, stream3, in_valid, out_ready,
    input  in_ready, pixel_out, out_valid, line_last, len_err
  );

  modport slave (
    input  stream1, stream2, stream3, in_valid, out_ready,
    output in_ready, pixel_out, out_valid, line_last, len_err
  );
endinterface

// File: rtl/rle_line_decoder.sv
// RLE line decoder: accepts a (black, white, black) run triple and expands it
// into exactly IMAGE_W pixels. Runs are turned into absolute boundaries
// b1/b2/b3 at acceptance so each pixel is a pair of compares against the
// running index. Over-long triples truncate (flagged on the last pixel with
// len_err), short ones are padded with black.
module rle_line_decoder #(
  parameter logic [10:0] IMAGE_W = 11'd25
) (
  input  logic              CLK,
  input  logic              RESET_N,
  rle_line_decoder_if.slave bus
);

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  state_t      state_reg;
  state_t      state_next;
  logic [11:0] b1_reg;
  logic [11:0] b2_reg;
  logic [11:0] b3_reg;
  logic [10:0] idx_reg;

  // Boundaries of the incoming triple; 12 bits so three 10-bit runs cannot wrap.
  logic [11:0] b1_in;
  logic [11:0] b2_in;
  logic [11:0] b3_in;
  logic [11:0] idx_ext;
  logic        at_last;
  logic        accept;
  logic        advance;

  assign b1_in   = {2'b00, bus.stream1};
  assign b2_in   = b1_in + {2'b00, bus.stream2};
  assign b3_in   = b2_in + {2'b00, bus.stream3};
  assign idx_ext = {1'b0, idx_reg};
  assign at_last = (idx_reg == (IMAGE_W - 11'd1));

  // State register; reset parks the decoder in IDLE and abandons any partial line.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and handshake/pixel outputs; everything downstream is gated by EMIT.
  always_comb begin
    state_next    = state_reg;
    accept        = 1'b0;
    advance       = 1'b0;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.pixel_out = 1'b0;
    bus.line_last = 1'b0;
    bus.len_err   = 1'b0;
    case (state_reg)
      IDLE: begin
        // Held low while reset is asserted even though the state already reads IDLE.
        bus.in_ready = RESET_N;
        if (RESET_N && bus.in_valid) begin
          accept     = 1'b1;
          state_next = EMIT;
        end
      end
      EMIT: begin
        bus.out_valid = 1'b1;
        bus.pixel_out = (idx_ext >= b1_reg) && (idx_ext < b2_reg);
        bus.line_last = at_last;
        bus.len_err   = at_last && (b3_reg > {1'b0, IMAGE_W});
        if (bus.out_ready) begin
          advance = 1'b1;
          if (at_last) begin
            state_next = IDLE;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Boundary latches and pixel index; index only moves on an accepted pixel.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      b1_reg  <= 12'd0;
      b2_reg  <= 12'd0;
      b3_reg  <= 12'd0;
      idx_reg <= 11'd0;
    end else if (accept) begin
      b1_reg  <= b1_in;
      b2_reg  <= b2_in;
      b3_reg  <= b3_in;
      idx_reg <= 11'd0;
    end else if (advance) begin
      idx_reg <= idx_reg + 11'd1;
    end
  end

endmodule

// File: tb/tb_rle_line_decoder.sv
// Bench for rle_line_decoder: a driver pushes the expected 25-pixel line for
// every accepted triple into a queue; a monitor pops one entry per pixel
// handshake and compares {pixel, line_last, len_err}.
module tb_rle_line_decoder;

  logic CLK = 1'b0;
  logic RESET_N;

  rle_line_decoder_if bus ();

  rle_line_decoder #(.IMAGE_W(11'd25)) dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .bus     (bus)
  );

  always #5 CLK = ~CLK;

  logic [2:0] exp_q[$];
  int n_vec   = 0;
  int n_err   = 0;
  int pop_cnt = 0;
  bit pat_mode = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Expected line built run by run: leading black, white, trailing black, pad black.
  task automatic push_line(input int a, input int b, input int c, input bit err);
    logic px[$];
    for (int i = 0; i < a; i++) px.push_back(1'b0);
    for (int i = 0; i < b; i++) px.push_back(1'b1);
    for (int i = 0; i < c; i++) px.push_back(1'b0);
    while (px.size() < 25) px.push_back(1'b0);
    for (int i = 0; i < 25; i++) begin
      exp_q.push_back({px[i], (i == 24), (i == 24) ? err : 1'b0});
    end
  endtask

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send(input int a, input int b, input int c, input bit err);
    int t = 0;
    while (!bus.in_ready && t < 300) begin
      @(posedge CLK); #1; t++;
    end
    if (!bus.in_ready) begin
      n_vec++; n_err++;
      $display("FAIL send_timeout: in_ready stayed %0b expected 1", bus.in_ready);
      return;
    end
    bus.stream1  = a[9:0];
    bus.stream2  = b[9:0];
    bus.stream3  = c[9:0];
    bus.in_valid = 1'b1;
    push_line(a, b, c, err);
    $display("send triple (%0d,%0d,%0d) err=%0b", a, b, c, err);
    @(posedge CLK); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int t = 0;
    while (exp_q.size() != 0 && t < 500) begin
      @(posedge CLK); #1; t++;
    end
    check(name, exp_q.size(), 0);
  endtask

  // out_ready: constantly high, or the repeating 1,0,0,1 pattern.
  initial begin
    int cyc = 0;
    bus.out_ready = 1'b1;
    forever begin
      @(posedge CLK); #1;
      cyc++;
      if (pat_mode) bus.out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      else          bus.out_ready = 1'b1;
    end
  end

  // Monitor: one comparison per pixel handshake, sampled on the falling edge.
  initial begin
    logic [2:0] got;
    logic [2:0] want;
    forever begin
      @(negedge CLK);
      if (RESET_N && bus.out_valid && bus.out_ready) begin
        got = {bus.pixel_out, bus.line_last, bus.len_err};
        if (exp_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_pixel: got {px,last,err}=%b expected none", got);
        end else begin
          want = exp_q.pop_front();
          pop_cnt++;
          check("pixel", {29'd0, got}, {29'd0, want});
        end
      end
    end
  end

  initial begin
    int cnt;
    int base;
    RESET_N      = 1'b0;
    bus.in_valid = 1'b0;
    bus.stream1  = '0;
    bus.stream2  = '0;
    bus.stream3  = '0;
    #1;
    check("rst_in_ready",  bus.in_ready,  0);
    check("rst_out_valid", bus.out_valid, 0);
    repeat (2) @(posedge CLK);
    #1;
    check("rst_pixel_flags", {bus.pixel_out, bus.line_last, bus.len_err}, 0);
    RESET_N = 1'b1;
    #1;
    check("rel_in_ready", bus.in_ready, 1);
    @(posedge CLK); #1;

    // (8,9,8): in_ready returns 25 edges after the accepting edge.
    send(8, 9, 8, 1'b0);
    cnt = 0;
    while (!bus.in_ready && cnt < 100) begin
      @(posedge CLK); #1; cnt++;
    end
    check("t1_ready_latency", cnt, 25);
    check("t1_queue_empty", exp_q.size(), 0);

    // Back-to-back lines, including pad, truncation and overflow cases.
    send(25, 0, 0, 1'b0);
    send(0, 25, 0, 1'b0);
    send(5, 10, 3, 1'b0);
    send(20, 10, 5, 1'b1);
    send(1023, 1023, 1023, 1'b1);
    drain("lines_drained");

    // Backpressure with ignored triples offered mid-line.
    pat_mode = 1'b1;
    send(8, 9, 8, 1'b0);
    for (int i = 0; i < 3; i++) begin
      bus.stream1  = 10'd1;
      bus.stream2  = 10'd1;
      bus.stream3  = 10'd1;
      bus.in_valid = 1'b1;
      check("emit_in_ready", bus.in_ready, 0);
      @(posedge CLK); #1;
    end
    bus.in_valid = 1'b0;
    drain("bp_drained");
    pat_mode = 1'b0;
    @(posedge CLK); #1;

    // Mid-line reset while pixel 12 is presented.
    base = pop_cnt;
    send(8, 9, 8, 1'b0);
    cnt = 0;
    while ((pop_cnt - base) < 11 && cnt < 100) begin
      @(posedge CLK); #1; cnt++;
    end
    check("pix12_reached", pop_cnt - base, 11);
    check("pix12_valid", bus.out_valid, 1);
    RESET_N = 1'b0;
    #1;
    check("mid_rst_out_valid", bus.out_valid, 0);
    check("mid_rst_in_ready",  bus.in_ready,  0);
    exp_q.delete();
    repeat (2) @(posedge CLK);
    #1;
    check("mid_rst_flags", {bus.pixel_out, bus.line_last, bus.len_err}, 0);
    RESET_N = 1'b1;
    #1;
    check("post_rst_in_ready", bus.in_ready, 1);
    send(3, 3, 3, 1'b0);
    drain("post_rst_drained");

    repeat (5) @(posedge CLK);
    #1;
    check("final_idle_out_valid", bus.out_valid, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rle_line_decoder.md
RLE_LINE_DECODER -- requirements
Module: rle_line_decoder

Interface
REQ-001 SHALL have parameter IMAGE_W, default 11'd25, meaning pixels per reconstructed line.
REQ-002 SHALL have port CLK  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port RESET_N  input  1  reset; one clock, reset asynchronous and active-low.
REQ-004 SHALL have port stream1  input  10  leading black run length.
REQ-005 SHALL have port stream2  input  10  white run length.
REQ-006 SHALL have port stream3  input  10  trailing black run length.
REQ-007 SHALL have port in_valid  input  1  run triple present.
REQ-008 SHALL have port in_ready  output  1  decoder can accept a triple.
REQ-009 SHALL have port pixel_out  output  1  reconstructed pixel; 0 = black, 1 = white.
REQ-010 SHALL have port out_valid  output  1  pixel_out valid.
REQ-011 SHALL have port out_ready  input  1  downstream accepts pixel.
REQ-012 SHALL have port line_last  output  1  qualifies the final pixel of a line.
REQ-013 SHALL have port len_err  output  1  run sum exceeded IMAGE_W; qualifies the final pixel.

Function
REQ-014 SHALL implement two states, IDLE and EMIT.
REQ-015 SHALL drive in_ready = 1 only in IDLE.
REQ-016 SHALL, on in_valid & in_ready, latch b1 = stream1, b2 = stream1+stream2, b3 = b2+stream3 as 12-bit unsigned, clear pixel index idx (11-bit), and enter EMIT.
REQ-017 SHALL ignore in_valid while in EMIT; latched boundaries stay unchanged.
REQ-018 SHALL assert out_valid throughout EMIT and only in EMIT; first pixel valid the cycle after acceptance (latency 1).
REQ-019 SHALL drive pixel_out = 1 iff b1 <= idx < b2, else 0; positions idx >= b3 are black padding.
REQ-020 SHALL advance idx by 1 only on out_valid & out_ready; with out_ready low, pixel_out, idx, line_last and len_err hold stable.
REQ-021 SHALL assert line_last iff EMIT and idx == IMAGE_W-1.
REQ-022 SHALL assert len_err iff EMIT and idx == IMAGE_W-1 and b3 > IMAGE_W.
REQ-023 SHALL emit exactly IMAGE_W pixels per accepted triple; a sum greater than IMAGE_W truncates and a sum less than IMAGE_W pads.
REQ-024 SHALL skip zero-length runs without bubbles.
REQ-025 SHALL, on handshake of the line_last pixel, return to IDLE.
REQ-026 SHALL insert exactly one IDLE cycle between lines; sustained throughput is IMAGE_W pixels per IMAGE_W+1 cycles.
REQ-027 SHALL perform no arithmetic wrap: 10-bit inputs summed into 12 bits, max 3069.

Reset
REQ-028 SHALL, while RESET_N = 0, force state IDLE, idx = 0, b1 = b2 = b3 = 0, and outputs in_ready = 0, out_valid = 0, pixel_out = 0, line_last = 0, len_err = 0.
REQ-029 SHALL drive in_ready = 1 the first cycle after RESET_N rises.
REQ-030 SHALL abandon a partial line on mid-line reset with no further pixels; the next accepted triple starts at idx 0.

Verification
REQ-031 SHALL cover: triple (8,9,8), out_ready = 1 -> 8x0, 9x1, 8x0; line_last on pixel 25; len_err = 0; in_ready high one cycle later.
REQ-032 SHALL cover: (25,0,0) -> 25x0, no white; then (0,25,0) -> 25x1.
REQ-033 SHALL cover: (5,10,3) -> 5x0, 10x1, 10x0 (3 run + 7 pad); len_err = 0.
REQ-034 SHALL cover: (20,10,5) -> 20x0, 5x1; len_err = 1 with line_last; then (1023,1023,1023) -> 25x0, len_err = 1.
REQ-035 SHALL cover: out_ready pattern 1,0,0,1 repeating with (8,9,8), plus in_valid pulses with (1,1,1) during EMIT -> identical 25-pixel sequence, no drop or duplicate, (1,1,1) ignored.
REQ-036 SHALL cover: RESET_N low during pixel 12 of (8,9,8) -> out_valid = 0 same cycle; after release, (3,3,3) decodes as 3x0, 3x1, 19x0.
